// File: rtl/io_port_bank_if.sv
// Register bus between the CPU and io_port_bank: one address, separate
// write and read strobes, registered read response with a valid flag.
interface io_port_bank_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        output addr, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid
    );

    modport slave (
        input  addr, wr_en, wr_data, rd_en,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/io_port_bank.sv
// Bank of NUM_PORTS output registers and synchronised, change-detected inputs
// with sticky per-port flags, per-port interrupt enables and one irq line.
module io_port_bank #(
    parameter int                    NUM_PORTS  = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 6,
    parameter logic [DATA_WIDTH-1:0] OUT_RESET  = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    io_port_bank_if.slave                   bus,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_in,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] port_out,
    output logic                            irq
);

    function automatic logic [DATA_WIDTH-1:0] ctrl_word(input logic flag, input logic en);
        return DATA_WIDTH'({flag, en});
    endfunction

    logic [ADDR_WIDTH-1:0] w_addr_raw;
    logic [31:0]           w_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_wr_en;
    logic                  w_rd_en;

    logic [DATA_WIDTH-1:0] w_port_in [NUM_PORTS];
    logic [NUM_PORTS-1:0]  w_dsel;
    logic [NUM_PORTS-1:0]  w_csel;
    logic [NUM_PORTS-1:0]  w_change;
    logic [DATA_WIDTH-1:0] w_rd_mux;

    logic [DATA_WIDTH-1:0] r_out     [NUM_PORTS];
    logic [DATA_WIDTH-1:0] r_sync_p0 [NUM_PORTS];
    logic [DATA_WIDTH-1:0] r_sync_p1 [NUM_PORTS];
    logic [DATA_WIDTH-1:0] r_last_p2 [NUM_PORTS];
    logic [NUM_PORTS-1:0]  r_flag;
    logic [NUM_PORTS-1:0]  r_irq_en;
    logic [1:0]            r_arm_cnt;
    logic                  r_armed;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    assign w_addr_raw = bus.addr;
    assign w_addr     = 32'(w_addr_raw);
    assign w_wr_data  = bus.wr_data;
    assign w_wr_en    = bus.wr_en;
    assign w_rd_en    = bus.rd_en;

    // Decode compares the zero-extended address against each port's slot, so
    // addresses at or above 2*NUM_PORTS select nothing and never alias.
    always_comb begin
        w_dsel    = '0;
        w_csel    = '0;
        w_change  = '0;
        w_port_in = '{default: '0};
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_port_in[k] = port_in[k*DATA_WIDTH +: DATA_WIDTH];
            w_dsel[k]    = (w_addr == 32'(k));
            w_csel[k]    = (w_addr == 32'(NUM_PORTS + k));
            w_change[k]  = r_armed && (r_sync_p1[k] != r_last_p2[k]);
        end
    end

    always_comb begin
        w_rd_mux = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (w_dsel[k])
                w_rd_mux = w_rd_mux | r_sync_p1[k];
            if (w_csel[k])
                w_rd_mux = w_rd_mux | ctrl_word(r_flag[k], r_irq_en[k]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_PORTS; k++)
                r_out[k] <= OUT_RESET;
        end else if (w_wr_en) begin
            for (int k = 0; k < NUM_PORTS; k++)
                if (w_dsel[k])
                    r_out[k] <= w_wr_data;
        end
    end

    // Stage p0/p1: two-flop synchroniser; stage p2: previous synchronised value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                r_sync_p0[k] <= '0;
                r_sync_p1[k] <= '0;
                r_last_p2[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                r_sync_p0[k] <= w_port_in[k];
                r_sync_p1[k] <= r_sync_p0[k];
                r_last_p2[k] <= r_sync_p1[k];
            end
        end
    end

    // Detection stays disarmed until the synchroniser chain has filled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_arm_cnt <= 2'd0;
            r_armed   <= 1'b0;
        end else if (!r_armed) begin
            r_arm_cnt <= r_arm_cnt + 2'd1;
            if (r_arm_cnt == 2'd2)
                r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flag   <= '0;
            r_irq_en <= '0;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (w_change[k])
                    r_flag[k] <= 1'b1;
                else if (w_wr_en && w_csel[k] && w_wr_data[1])
                    r_flag[k] <= 1'b0;
                if (w_wr_en && w_csel[k])
                    r_irq_en[k] <= w_wr_data[0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_rd_en)
                r_rd_data <= w_rd_mux;
        end
    end

    always_comb begin
        port_out = '0;
        for (int k = 0; k < NUM_PORTS; k++)
            port_out[k*DATA_WIDTH +: DATA_WIDTH] = r_out[k];
    end

    assign irq          = |(r_flag & r_irq_en);
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank: reset, data/control access, change
// detection, set-over-clear priority, unmapped addresses and async reset.
module tb_io_port_bank;
    localparam int             NP   = 16;
    localparam int             DW   = 8;
    localparam int             AW   = 6;
    localparam logic [DW-1:0]  ORST = 8'h5A;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP*DW-1:0]  port_in;
    logic [NP*DW-1:0]  port_out;
    logic [NP*DW-1:0]  exp_out;
    logic              irq;
    int                total = 0;
    int                bad   = 0;

    io_port_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    io_port_bank #(
        .NUM_PORTS (NP),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .OUT_RESET (ORST)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .port_in (port_in),
        .port_out(port_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [NP*DW-1:0] obs, input logic [NP*DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setp(input int k, input logic [DW-1:0] v);
        port_in[k*DW +: DW] = v;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.addr    = a;
        bus.wr_data = d;
        bus.wr_en   = 1'b1;
        cyc(1);
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        cyc(1);
        bus.rd_en = 1'b0;
        chk({tag, "_vld"}, NP*DW'(bus.rd_valid), NP*DW'(1'b1));
        chk(tag, NP*DW'(bus.rd_data), NP*DW'(exp));
    endtask

    initial begin
        reset       = 1'b1;
        port_in     = '0;
        bus.addr    = '0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        setp(3, 8'hAA);
        setp(2, 8'h11);
        exp_out = {NP{ORST}};

        // 1: reset values, no false flags from synchroniser fill
        #1;
        chk("rst_out", port_out, exp_out);
        chk("rst_vld", NP*DW'(bus.rd_valid), '0);
        chk("rst_irq", NP*DW'(irq), '0);
        cyc(2);
        reset = 1'b0;
        cyc(6);
        chk("arm_irq", NP*DW'(irq), '0);
        rd(AW'(NP + 3), 8'h00, "arm_ctrl3");
        rd(AW'(3), 8'hAA, "arm_data3");

        // 2: data write, read returns synchronised input
        chk("wr2_before", port_out, exp_out);
        wr(AW'(2), 8'hC3);
        exp_out[2*DW +: DW] = 8'hC3;
        chk("wr2_after", port_out, exp_out);
        bus.addr  = AW'(2);
        bus.rd_en = 1'b1;
        chk("rd2_lat", NP*DW'(bus.rd_valid), '0);
        cyc(1);
        bus.rd_en = 1'b0;
        chk("rd2_vld", NP*DW'(bus.rd_valid), NP*DW'(1'b1));
        chk("rd2_data", NP*DW'(bus.rd_data), NP*DW'(8'h11));
        cyc(1);
        chk("rd2_vld_drop", NP*DW'(bus.rd_valid), '0);
        chk("rd2_hold", NP*DW'(bus.rd_data), NP*DW'(8'h11));

        // 3: change detect on port 4 with irq enabled
        wr(AW'(NP + 4), 8'h01);
        setp(4, 8'h7F);
        cyc(1);
        chk("p4_irq_e1", NP*DW'(irq), '0);
        cyc(1);
        chk("p4_irq_e2", NP*DW'(irq), '0);
        cyc(1);
        chk("p4_irq_e3", NP*DW'(irq), NP*DW'(1'b1));
        rd(AW'(NP + 4), 8'h03, "p4_ctrl_set");
        wr(AW'(NP + 4), 8'h03);
        chk("p4_irq_clr", NP*DW'(irq), '0);
        rd(AW'(NP + 4), 8'h01, "p4_ctrl_clr");

        // 4: set wins over a clear landing on the same edge
        wr(AW'(NP + 6), 8'h01);
        setp(6, 8'h01);
        cyc(4);
        chk("p6_irq_set", NP*DW'(irq), NP*DW'(1'b1));
        setp(6, 8'h00);
        cyc(2);
        bus.addr    = AW'(NP + 6);
        bus.wr_data = 8'h03;
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        cyc(1);
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        chk("p6_rw_vld", NP*DW'(bus.rd_valid), NP*DW'(1'b1));
        chk("p6_rw_pre", NP*DW'(bus.rd_data), NP*DW'(8'h03));
        chk("p6_irq_kept", NP*DW'(irq), NP*DW'(1'b1));
        rd(AW'(NP + 6), 8'h03, "p6_ctrl_kept");
        wr(AW'(NP + 6), 8'h02);
        rd(AW'(NP + 6), 8'h00, "p6_ctrl_off");
        chk("p6_irq_off", NP*DW'(irq), '0);

        // 5: unmapped address
        rd(AW'(2), 8'h11, "pre_unmap");
        rd(AW'(2*NP + 1), 8'h00, "unmap_rd");
        wr(AW'(2*NP + 1), 8'hFF);
        chk("unmap_out", port_out, exp_out);
        rd(AW'(NP + 1), 8'h00, "unmap_ctrl1");
        chk("unmap_irq", NP*DW'(irq), '0);

        // 6: asynchronous reset during a read
        wr(AW'(0), 8'hFF);
        exp_out[0 +: DW] = 8'hFF;
        chk("p0_ff", port_out, exp_out);
        wr(AW'(NP + 1), 8'h01);
        setp(1, 8'h05);
        cyc(4);
        chk("p1_irq", NP*DW'(irq), NP*DW'(1'b1));
        bus.addr  = AW'(0);
        bus.rd_en = 1'b1;
        @(posedge clk);
        #2;
        chk("mid_vld", NP*DW'(bus.rd_valid), NP*DW'(1'b1));
        reset = 1'b1;
        #1;
        exp_out = {NP{ORST}};
        chk("arst_out", port_out, exp_out);
        chk("arst_irq", NP*DW'(irq), '0);
        chk("arst_vld", NP*DW'(bus.rd_valid), '0);
        cyc(1);
        bus.rd_en = 1'b0;
        reset     = 1'b0;
        cyc(1);
        chk("post_vld1", NP*DW'(bus.rd_valid), '0);
        cyc(1);
        chk("post_vld2", NP*DW'(bus.rd_valid), '0);
        cyc(4);
        rd(AW'(NP + 1), 8'h00, "post_ctrl1");
        rd(AW'(NP + 3), 8'h00, "post_ctrl3");
        chk("post_irq", NP*DW'(irq), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
Parametrised successor to the CPU's fixed 16×8-bit I/O port array. It has NUM_PORTS output registers and NUM_PORTS input ports, each DATA_WIDTH wide. Every input passes through a two-stage synchroniser and a change detector that sets a sticky per-port flag. The flags, gated by per-port enables, drive a single interrupt line. The CPU accesses the bank through a simple registered read/write bus.

Parameters:
NUM_PORTS, 16, number of input and of output ports (1..32)
DATA_WIDTH, 8, width of each port and of the bus data (≥2)
ADDR_WIDTH, 6, bus address width; must satisfy 2^ADDR_WIDTH ≥ 2*NUM_PORTS
OUT_RESET, 0, reset value of every output register (DATA_WIDTH bits)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
addr  in  ADDR_WIDTH  bus address
wr_en  in  1  write strobe, sampled on clk
wr_data  in  DATA_WIDTH  write data
rd_en  in  1  read strobe, sampled on clk
rd_data  out  DATA_WIDTH  registered read data
rd_valid  out  1  high for one cycle when rd_data holds a response
port_in  in  NUM_PORTS*DATA_WIDTH  external inputs, port k at bits [k*DATA_WIDTH +: DATA_WIDTH], asynchronous to clk
port_out  out  NUM_PORTS*DATA_WIDTH  output registers, same packing
irq  out  1  OR over k of (flag[k] & irq_en[k])

Behaviour:
- Address map:
  - 0..NUM_PORTS-1: data port k.
  - NUM_PORTS..2*NUM_PORTS-1: control/status of port k = addr-NUM_PORTS.
  - Higher addresses: reads return 0 with rd_valid=1; writes are ignored.
- Write to data k: port_out[k] <= wr_data at that edge, visible the next cycle.
- Write to control k:
  - bit0 sets irq_en[k] <= wr_data[0].
  - bit1=1 clears flag[k]; bit1=0 leaves it unchanged.
  - Other bits are ignored.
- Read, 1-cycle latency: rd_en sampled at edge t gives rd_data/rd_valid valid after edge t, until edge t+1.
  - rd_valid=0 whenever rd_en was 0; rd_data then holds its last value.
  - Data k returns the synchronised input s2[k], not port_out.
  - Control k returns {0…, flag[k], irq_en[k]} in bits [1:0].
- Read and write in the same cycle are both performed. A read returns the pre-write state: e.g. a control read concurrent with a clear returns flag=1.
- Synchroniser per port: s1 <= port_in; s2 <= s1; last <= s2.
  - An input change sampled at edge t appears in s2 after edge t+1. It is readable by a read strobed at edge t+2.
- Change detect: at each edge, if armed and s2[k] != last[k], then flag[k] <= 1.
  - Set has priority over a same-cycle clear: the flag stays 1.
  - The flag stays set until cleared by software.
- Arming:
  - A 2-bit counter starts counting after reset is released.
  - armed goes high after the 3rd rising edge following release.
  - While unarmed, no flags set, so post-reset synchroniser fill does not raise false flags.
- irq is combinational from the flag and irq_en registers; it has no extra latency beyond the flag register.
- Reset (asynchronous, any time, including mid-transaction):
  - port_out = OUT_RESET for all ports.
  - s1, s2, last, flag, irq_en, rd_data, rd_valid = 0; arm counter = 0, armed = 0; irq = 0.
  - A read pending at reset produces no response.
- Multiple ports may flag in the same cycle; each flag is independent.
- A change lasting a single clk cycle is still flagged once it reaches s2.

Test Plan:
1. Reset with OUT_RESET=8'h5A; hold reset 2 cycles, release -> every port_out=8'h5A, rd_valid=0, irq=0; no flags set even with port_in[3]=8'hAA held throughout.
2. Write addr=2, wr_data=8'hC3, then read addr=2 with port_in[2]=8'h11 stable -> port_out[2]=8'hC3 from the next cycle; the read returns rd_data=8'h11 with rd_valid=1 exactly one cycle after rd_en.
3. Write addr=NUM_PORTS+4 data=8'h01 (irq_en[4]=1), then change port_in[4] 8'h00→8'h7F -> flag[4]=1 and irq=1 three edges after the change. A control read returns 8'h03. Write data=8'h03 -> flag clears, irq=0.
4. Toggle port_in[6] in the same cycle the clear write to addr=NUM_PORTS+6 is sampled -> the flag stays 1 (set wins). A concurrent read returns pre-clear bits [1:0]=2'b11.
5. Read addr=2*NUM_PORTS+1 (unmapped) -> rd_data=0, rd_valid=1. A write to that address changes no port_out or control state.
6. Assert reset mid-read (rd_en high) with port_out[0]=8'hFF and flag[1]=1 -> outputs reset immediately, asynchronously: port_out[0]=OUT_RESET, irq=0, no rd_valid pulse after release.
